rx_frame_ctrl: RTL and testbench
================================

Name: rx_frame_ctrl

Overview:
- Receive-side sequencer for the UART RX path.
- Oversamples RX_IN at Prescale clocks per bit, majority-votes each bit and deserialises 8 data bits LSB first.
- Drives par_chk_en and sampled_bit to the combinational parity checker and consumes its par_err result.
- Checks start glitch and stop bit; issues a one-cycle data_valid per clean frame.

Parameters:
DATA_W, 8, data bits per frame (fixed at 8 for this revision)
PRESC_W, 6, width of Prescale input

Ports:
CLK  input  1  system clock
RST  input  1  asynchronous active-high reset
RX_IN  input  1  serial line, idle high, already synchronised to CLK
Prescale  input  6  clocks per bit; legal even values 8..32 (8/16/32 in use); static while a frame is active
PAR_EN  input  1  parity bit present; sampled at start detect
par_err  input  1  parity checker result, combinational from P_DATA/sampled_bit
par_chk_en  output  1  enable to parity checker
sampled_bit  output  1  majority-voted value of current bit
P_DATA  output  8  received byte
data_valid  output  1  one-cycle pulse, frame accepted
frame_par_err  output  1  one-cycle pulse, parity failed
frame_stp_err  output  1  one-cycle pulse, stop bit low
strt_glitch  output  1  one-cycle pulse, start bit rejected

Behaviour:
- Reset (async, RST=1): state IDLE; all counters 0; P_DATA=0, sampled_bit=1; all outputs 0; par_en latch 0. Reset mid-frame aborts the frame immediately with no pulses.
- edge_cnt counts 0..Prescale-1 within each bit and wraps to 0 at Prescale-1. bit_cnt counts data bits 0..7.
- Sampling: RX_IN sampled at edge_cnt = P/2-2, P/2-1 and P/2. Majority of the three registered into sampled_bit at the end of the edge P/2 cycle, so it is valid from edge P/2+1. Sampling runs in every non-IDLE state.
- IDLE: RX_IN=0 -> START with edge_cnt=0 on the next cycle; latch PAR_EN. Otherwise stay.
- START: at edge P-1, sampled_bit=1 -> IDLE with strt_glitch pulse; otherwise -> DATA with bit_cnt=0.
- DATA:
  - At edge P/2+1, P_DATA shifts right with sampled_bit entering bit 7, so it is LSB-first correct after 8 bits.
  - At edge P-1: bit_cnt=7 -> PARITY if latched PAR_EN else STOP; otherwise bit_cnt+1.
- PARITY:
  - par_chk_en=1 while edge_cnt >= P/2+1; 0 in every other state and cycle.
  - par_err captured at edge P-1 into an internal flag; -> STOP.
- STOP: at edge P-1, stp_flag = ~sampled_bit; -> IDLE. Exactly one of the following in the next cycle:
  - no errors: data_valid=1.
  - parity flag set: frame_par_err=1.
  - stop flag set: frame_stp_err=1. Both error pulses may assert together.
  - data_valid is never asserted with either error.
- Pulses last exactly one cycle.
- P_DATA holds its last value until the next frame's first data-bit shift.
- Back-to-back frames: the start falling edge may arrive in the data_valid cycle. IDLE detects it in that same cycle; up to one cycle of slip per frame is tolerated.
- RX_IN low throughout a frame: stop fails and frame_stp_err pulses. IDLE then re-detects start on the next cycle.
- Frame length, measured from the IDLE cycle seeing RX_IN=0 to the pulse: 1 + Prescale*(10+PAR_EN) cycles.

Test Plan:
- Prescale=8, PAR_EN=0, send 0xA5 (start, 1,0,1,0,0,1,0,1, stop) -> P_DATA=0xA5; data_valid single pulse 81 cycles after start detect; no error pulses.
- Prescale=16, PAR_EN=1, even parity, send 0x3C with parity 0 -> par_chk_en high 7 cycles in parity bit; data_valid pulse; P_DATA=0x3C. Same byte with parity 1 -> frame_par_err pulse, no data_valid.
- Prescale=8, RX_IN low for 2 cycles only (glitch) -> strt_glitch pulse at end of start bit, return to IDLE, no data_valid.
- Prescale=8, PAR_EN=0, stop bit driven 0, send 0xFF -> frame_stp_err pulse, no data_valid, P_DATA=0xFF.
- Single-cycle low spike at edge P/2-1 of each data bit sending 0xFF -> majority gives P_DATA=0xFF, data_valid.
- Assert RST during bit 4 of a frame -> outputs 0 immediately; a subsequent clean frame 0x5A is received correctly; back-to-back 0x01, 0x80 both produce data_valid.

Source files
------------

// File: rtl/rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : rx_frame_ctrl
// Brief   : UART RX sequencer - oversampled majority-vote deframer with
//           start-glitch, parity and stop checks.
// Rev     : 1.0  initial release
// ============================================================================
module rx_frame_ctrl #(
    parameter int DATA_W  = 8,
    parameter int PRESC_W = 6
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               RX_IN,
    input  logic [PRESC_W-1:0] Prescale,
    input  logic               PAR_EN,
    input  logic               par_err,
    output logic               par_chk_en,
    output logic               sampled_bit,
    output logic [DATA_W-1:0]  P_DATA,
    output logic               data_valid,
    output logic               frame_par_err,
    output logic               frame_stp_err,
    output logic               strt_glitch
);

    localparam int BIT_W = $clog2(DATA_W);
    localparam logic [BIT_W-1:0] C_LAST_BIT = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [PRESC_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [1:0]         vote_q, vote_d;
    logic               sampled_bit_q, sampled_bit_d;
    logic [DATA_W-1:0]  p_data_q, p_data_d;
    logic               par_en_q, par_en_d;
    logic               par_flag_q, par_flag_d;
    logic               data_valid_q, data_valid_d;
    logic               frame_par_err_q, frame_par_err_d;
    logic               frame_stp_err_q, frame_stp_err_d;
    logic               strt_glitch_q, strt_glitch_d;

    logic [PRESC_W-1:0] w_half;
    logic               w_edge_last;
    logic               w_stp_bad;

    assign w_half      = {1'b0, Prescale[PRESC_W-1:1]};
    assign w_edge_last = (edge_cnt_q == Prescale - PRESC_W'(1));

    always_comb begin
        state_d         = state_q;
        edge_cnt_d      = edge_cnt_q;
        bit_cnt_d       = bit_cnt_q;
        vote_d          = vote_q;
        sampled_bit_d   = sampled_bit_q;
        p_data_d        = p_data_q;
        par_en_d        = par_en_q;
        par_flag_d      = par_flag_q;
        data_valid_d    = 1'b0;
        frame_par_err_d = 1'b0;
        frame_stp_err_d = 1'b0;
        strt_glitch_d   = 1'b0;
        w_stp_bad       = 1'b0;

        // Three samples straddle mid-bit; the vote lands at the end of edge P/2.
        if (state_q != S_IDLE) begin
            edge_cnt_d = w_edge_last ? '0 : edge_cnt_q + PRESC_W'(1);
            if (edge_cnt_q == w_half - PRESC_W'(2)) vote_d[0] = RX_IN;
            if (edge_cnt_q == w_half - PRESC_W'(1)) vote_d[1] = RX_IN;
            if (edge_cnt_q == w_half) begin
                sampled_bit_d = (vote_q[0] & vote_q[1]) | (vote_q[0] & RX_IN) |
                                (vote_q[1] & RX_IN);
            end
        end

        case (state_q)
            S_IDLE: begin
                edge_cnt_d = '0;
                if (!RX_IN) begin
                    state_d    = S_START;
                    par_en_d   = PAR_EN;
                    par_flag_d = 1'b0;
                end
            end
            S_START: begin
                if (w_edge_last) begin
                    if (sampled_bit_q) begin
                        state_d       = S_IDLE;
                        strt_glitch_d = 1'b1;
                    end else begin
                        state_d   = S_DATA;
                        bit_cnt_d = '0;
                    end
                end
            end
            S_DATA: begin
                if (edge_cnt_q == w_half + PRESC_W'(1)) begin
                    p_data_d = {sampled_bit_q, p_data_q[DATA_W-1:1]};
                end
                if (w_edge_last) begin
                    if (bit_cnt_q == C_LAST_BIT) begin
                        state_d = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (w_edge_last) begin
                    par_flag_d = par_err;
                    state_d    = S_STOP;
                end
            end
            S_STOP: begin
                if (w_edge_last) begin
                    w_stp_bad       = ~sampled_bit_q;
                    state_d         = S_IDLE;
                    frame_par_err_d = par_flag_q;
                    frame_stp_err_d = w_stp_bad;
                    data_valid_d    = ~par_flag_q & ~w_stp_bad;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q         <= S_IDLE;
            edge_cnt_q      <= '0;
            bit_cnt_q       <= '0;
            vote_q          <= '0;
            sampled_bit_q   <= 1'b1;
            p_data_q        <= '0;
            par_en_q        <= 1'b0;
            par_flag_q      <= 1'b0;
            data_valid_q    <= 1'b0;
            frame_par_err_q <= 1'b0;
            frame_stp_err_q <= 1'b0;
            strt_glitch_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            edge_cnt_q      <= edge_cnt_d;
            bit_cnt_q       <= bit_cnt_d;
            vote_q          <= vote_d;
            sampled_bit_q   <= sampled_bit_d;
            p_data_q        <= p_data_d;
            par_en_q        <= par_en_d;
            par_flag_q      <= par_flag_d;
            data_valid_q    <= data_valid_d;
            frame_par_err_q <= frame_par_err_d;
            frame_stp_err_q <= frame_stp_err_d;
            strt_glitch_q   <= strt_glitch_d;
        end
    end

    assign par_chk_en    = (state_q == S_PARITY) && (edge_cnt_q >= w_half + PRESC_W'(1));
    assign sampled_bit   = sampled_bit_q;
    assign P_DATA        = p_data_q;
    assign data_valid    = data_valid_q;
    assign frame_par_err = frame_par_err_q;
    assign frame_stp_err = frame_stp_err_q;
    assign strt_glitch   = strt_glitch_q;

endmodule
`default_nettype wire

// File: tb/tb_rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_rx_frame_ctrl
// Brief   : Frame-level scoreboard bench for rx_frame_ctrl.
// Rev     : 1.0  initial release
// ============================================================================
module tb_rx_frame_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       RX_IN = 1'b1;
    logic       PAR_EN = 1'b0;
    logic [5:0] Prescale = 6'd8;
    logic       par_err;
    logic       par_chk_en;
    logic       sampled_bit;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       frame_par_err;
    logic       frame_stp_err;
    logic       strt_glitch;

    always #5 CLK = ~CLK;

    // Even-parity checker living outside the block
    assign par_err = (^P_DATA) ^ sampled_bit;

    rx_frame_ctrl #(.DATA_W(8), .PRESC_W(6)) u_dut (
        .CLK           (CLK),
        .RST           (RST),
        .RX_IN         (RX_IN),
        .Prescale      (Prescale),
        .PAR_EN        (PAR_EN),
        .par_err       (par_err),
        .par_chk_en    (par_chk_en),
        .sampled_bit   (sampled_bit),
        .P_DATA        (P_DATA),
        .data_valid    (data_valid),
        .frame_par_err (frame_par_err),
        .frame_stp_err (frame_stp_err),
        .strt_glitch   (strt_glitch)
    );

    // kind = {data_valid, frame_par_err, frame_stp_err, strt_glitch}
    typedef struct {
        logic [3:0] kind;
        logic [7:0] data;
        int         cyc;
        int         pchk;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         prev_exp = 0;
    int         last_slip = 0;
    int         pchk_cnt = 0;
    logic [7:0] last_data = 8'h00;
    logic [5:0] presc_tbl[3] = '{6'd8, 6'd16, 6'd32};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    // Monitor: every pulse consumes one scoreboard entry
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (RST) begin
                pchk_cnt = 0;
            end else begin
                if (par_chk_en) pchk_cnt++;
                if (data_valid | frame_par_err | frame_stp_err | strt_glitch) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_pulse",
                            {data_valid, frame_par_err, frame_stp_err, strt_glitch}, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("pulse_kind",
                            {data_valid, frame_par_err, frame_stp_err, strt_glitch}, e.kind);
                        chk("p_data", P_DATA, e.data);
                        chk("pulse_cycle", cyc, e.cyc);
                        chk("par_chk_cycles", pchk_cnt, e.pchk);
                    end
                    pchk_cnt = 0;
                end
            end
        end
    end

    // Start is detected when the line falls, unless the block is still
    // finishing the previous frame; then it sees it in the pulse cycle.
    function automatic int detect_cycle();
        return (cyc < prev_exp) ? prev_exp : cyc;
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic pe, input logic pbit,
                              input logic stop_ok, input logic spike);
        int          p, h, det, nb;
        logic        perr, serr;
        logic [10:0] bits;
        exp_t        e;
        p         = int'(Prescale);
        h         = p / 2;
        det       = detect_cycle();
        last_slip = det - cyc;
        perr      = pe && (pbit != ^d);
        serr      = !stop_ok;
        e.kind    = {!perr && !serr, perr, serr, 1'b0};
        e.data    = d;
        e.cyc     = det + 1 + p * (10 + int'(pe));
        e.pchk    = pe ? (h - 1) : 0;
        sb.push_back(e);
        prev_exp  = e.cyc;
        last_data = d;
        bits      = pe ? {stop_ok, pbit, d, 1'b0} : {1'b1, stop_ok, d, 1'b0};
        nb        = pe ? 11 : 10;
        PAR_EN    = pe;
        for (int b = 0; b < nb; b++) begin
            for (int k = 0; k < p; k++) begin
                RX_IN = (spike && b >= 1 && b <= 8 && k == h) ? ~bits[b] : bits[b];
                @(posedge CLK);
                #1;
            end
        end
        RX_IN = 1'b1;
    endtask

    task automatic send_glitch(input int len);
        exp_t e;
        e.kind   = 4'b0001;
        e.data   = last_data;
        e.cyc    = detect_cycle() + 1 + int'(Prescale);
        e.pchk   = 0;
        sb.push_back(e);
        prev_exp = e.cyc;
        RX_IN    = 1'b0;
        repeat (len) begin
            @(posedge CLK);
            #1;
        end
        RX_IN = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 4000) begin
            @(posedge CLK);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        idle(2);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_p_data"}, P_DATA, 0);
        chk({tag, "_sampled_bit"}, sampled_bit, 1);
        chk({tag, "_pulses"}, {data_valid, frame_par_err, frame_stp_err, strt_glitch}, 0);
        chk({tag, "_par_chk_en"}, par_chk_en, 0);
    endtask

    // Drives start plus data bits 0..3 and part of bit 4, then resets.
    task automatic abort_frame(input logic [7:0] d);
        int         p;
        logic [9:0] bits;
        p    = int'(Prescale);
        bits = {1'b1, d, 1'b0};
        for (int i = 0; i < 5 * p + 3; i++) begin
            RX_IN = bits[i / p];
            @(posedge CLK);
            #1;
        end
        chk("pre_abort_p_data_nonzero", (P_DATA != 8'h00), 1);
        RST = 1'b1;
        #1;
        check_reset_state("abort");
        RX_IN = 1'b1;
        idle(2);
        RST       = 1'b0;
        prev_exp  = 0;
        last_data = 8'h00;
        idle(2);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        int         gap;
        logic [7:0] d;
        logic       pe, pbit;
        idle(3);
        check_reset_state("reset");
        RST = 1'b0;
        idle(3);

        Prescale = 6'd8;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
        drain();

        Prescale = 6'd16;
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(3);
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0);
        drain();

        Prescale = 6'd8;
        send_glitch(2);
        drain();
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
        drain();
        send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 1'b1);
        drain();

        abort_frame(8'hFF);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0);
        drain();
        send_frame(8'h01, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(8'h80, 1'b0, 1'b0, 1'b1, 1'b0);
        drain();

        for (int g = 0; g < 4; g++) begin
            drain();
            Prescale = presc_tbl[$urandom_range(0, 2)];
            for (int f = 0; f < 6; f++) begin
                gap = $urandom_range(0, 3);
                if (last_slip > 0 && gap < 2) gap = 2;
                idle(gap);
                d    = 8'($urandom);
                pe   = 1'($urandom_range(0, 1));
                pbit = (^d) ^ ($urandom_range(0, 3) == 0);
                send_frame(d, pe, pbit, ($urandom_range(0, 6) != 0), 1'b0);
            end
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
